// File: rtl/ms5803_seq.sv
// MS5803 pressure-sensor sequencer: reset + PROM calibration readout, then D1/D2
// conversion cycles through a byte-command I2C controller (addr/wr_en/rd_en/rdata/rdy).
module ms5803_seq #(
    parameter logic [2:0] OSR_CODE  = 3'd4,
    parameter int         RST_WAIT  = 300000,
    parameter int         CONV_WAIT = 1000000,
    parameter int         TIMEOUT   = 200000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_auto_en,
    output logic [7:0]  o_i2c_addr,
    output logic        o_i2c_wr_en,
    output logic        o_i2c_rd_en,
    input  logic [23:0] i_i2c_rdata,
    input  logic        i_i2c_rdata_vld,
    input  logic        i_i2c_rdy,
    output logic [15:0] o_c1,
    output logic [15:0] o_c2,
    output logic [15:0] o_c3,
    output logic [15:0] o_c4,
    output logic [15:0] o_c5,
    output logic [15:0] o_c6,
    output logic        o_cal_vld,
    output logic [23:0] o_d1,
    output logic [23:0] o_d2,
    output logic        o_sample_vld,
    output logic        o_busy,
    output logic        o_err
);
    localparam logic [7:0]  L_CMD_RST  = 8'h1E;
    localparam logic [7:0]  L_CMD_D1   = 8'h40 + {4'd0, OSR_CODE, 1'b0};
    localparam logic [7:0]  L_CMD_D2   = 8'h50 + {4'd0, OSR_CODE, 1'b0};
    localparam logic [7:0]  L_CMD_ADC  = 8'h00;
    localparam logic [31:0] L_RST_WAIT = 32'(RST_WAIT);
    localparam logic [31:0] L_CNV_WAIT = 32'(CONV_WAIT);
    localparam logic [31:0] L_TO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_RST_CMD, S_RST_WAIT, S_RST_DLY, S_PROM_CMD, S_PROM_WAIT, S_IDLE,
        S_D1_CMD, S_D1_WAIT, S_D1_CONV, S_D1_RD, S_D1_RDW,
        S_D2_CMD, S_D2_WAIT, S_D2_CONV, S_D2_RD, S_D2_RDW, S_DONE, S_ERR
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_addr, w_addr_nxt;
    logic        r_wr_en, r_rd_en, w_wr_nxt, w_rd_nxt;
    logic [2:0]  r_idx;
    logic [31:0] r_dly, r_to_cnt, w_dly_val;
    logic        r_seen_lo;
    logic [15:0] r_c [1:6];
    logic [23:0] r_d1, r_d2;
    logic        r_cal_vld, r_sample_vld, r_busy, r_err;
    logic        w_wr_wait, w_rd_wait, w_done, w_dly_ld, w_cal_ld, w_d1_ld, w_d2_ld;

    // The controller may still show rdy for a few cycles after our pulse, so a
    // write only completes once rdy has been seen low and then high again.
    always_comb begin
        w_wr_wait = (r_state == S_RST_WAIT) || (r_state == S_D1_WAIT) || (r_state == S_D2_WAIT);
        w_rd_wait = (r_state == S_PROM_WAIT) || (r_state == S_D1_RDW) || (r_state == S_D2_RDW);
        w_done    = (w_wr_wait && i_i2c_rdy && r_seen_lo) || (w_rd_wait && i_i2c_rdata_vld);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wr_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
        w_dly_ld    = 1'b0;
        w_dly_val   = L_RST_WAIT;
        w_cal_ld    = 1'b0;
        w_d1_ld     = 1'b0;
        w_d2_ld     = 1'b0;
        case (r_state)
            S_RST_CMD: if (i_i2c_rdy) begin
                w_wr_nxt = 1'b1; w_addr_nxt = L_CMD_RST; w_state_nxt = S_RST_WAIT;
            end
            S_RST_WAIT: if (w_done) begin
                w_dly_ld = 1'b1; w_dly_val = L_RST_WAIT; w_state_nxt = S_RST_DLY;
            end
            S_RST_DLY: if (r_dly == 32'd0) w_state_nxt = S_PROM_CMD;
            S_PROM_CMD: if (i_i2c_rdy) begin
                w_rd_nxt = 1'b1; w_addr_nxt = 8'hA0 + {4'd0, r_idx, 1'b0}; w_state_nxt = S_PROM_WAIT;
            end
            S_PROM_WAIT: if (w_done) begin
                w_cal_ld    = 1'b1;
                w_state_nxt = (r_idx == 3'd6) ? S_IDLE : S_PROM_CMD;
            end
            // Issuing straight from IDLE gives the one-cycle start-to-pulse latency.
            S_IDLE: if (i_start || i_auto_en) begin
                if (i_i2c_rdy) begin
                    w_wr_nxt = 1'b1; w_addr_nxt = L_CMD_D1; w_state_nxt = S_D1_WAIT;
                end else begin
                    w_state_nxt = S_D1_CMD;
                end
            end
            S_D1_CMD: if (i_i2c_rdy) begin
                w_wr_nxt = 1'b1; w_addr_nxt = L_CMD_D1; w_state_nxt = S_D1_WAIT;
            end
            S_D1_WAIT: if (w_done) begin
                w_dly_ld = 1'b1; w_dly_val = L_CNV_WAIT; w_state_nxt = S_D1_CONV;
            end
            S_D1_CONV: if (r_dly == 32'd0) w_state_nxt = S_D1_RD;
            S_D1_RD: if (i_i2c_rdy) begin
                w_rd_nxt = 1'b1; w_addr_nxt = L_CMD_ADC; w_state_nxt = S_D1_RDW;
            end
            S_D1_RDW: if (w_done) begin
                w_d1_ld = 1'b1; w_state_nxt = S_D2_CMD;
            end
            S_D2_CMD: if (i_i2c_rdy) begin
                w_wr_nxt = 1'b1; w_addr_nxt = L_CMD_D2; w_state_nxt = S_D2_WAIT;
            end
            S_D2_WAIT: if (w_done) begin
                w_dly_ld = 1'b1; w_dly_val = L_CNV_WAIT; w_state_nxt = S_D2_CONV;
            end
            S_D2_CONV: if (r_dly == 32'd0) w_state_nxt = S_D2_RD;
            S_D2_RD: if (i_i2c_rdy) begin
                w_rd_nxt = 1'b1; w_addr_nxt = L_CMD_ADC; w_state_nxt = S_D2_RDW;
            end
            S_D2_RDW: if (w_done) begin
                w_d2_ld = 1'b1; w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_RST_CMD;
        endcase
        if ((w_wr_wait || w_rd_wait) && !w_done && (r_to_cnt >= L_TO_LAST))
            w_state_nxt = S_ERR;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_RST_CMD;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= 8'd0; r_wr_en <= 1'b0; r_rd_en <= 1'b0;
            r_idx <= 3'd1; r_dly <= 32'd0; r_to_cnt <= 32'd0; r_seen_lo <= 1'b0;
            for (int i = 1; i <= 6; i++) r_c[i] <= 16'd0;
            r_d1 <= 24'd0; r_d2 <= 24'd0;
            r_cal_vld <= 1'b0; r_sample_vld <= 1'b0; r_busy <= 1'b1; r_err <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_wr_en <= w_wr_nxt;
            r_rd_en <= w_rd_nxt;
            if (w_wr_nxt || w_rd_nxt) begin
                r_to_cnt  <= 32'd0;
                r_seen_lo <= 1'b0;
            end else if (w_wr_wait || w_rd_wait) begin
                r_to_cnt <= r_to_cnt + 32'd1;
                if (!i_i2c_rdy) r_seen_lo <= 1'b1;
            end
            if (w_dly_ld)             r_dly <= w_dly_val;
            else if (r_dly != 32'd0)  r_dly <= r_dly - 32'd1;
            if (w_cal_ld) begin
                case (r_idx)
                    3'd1:    r_c[1] <= i_i2c_rdata[23:8];
                    3'd2:    r_c[2] <= i_i2c_rdata[23:8];
                    3'd3:    r_c[3] <= i_i2c_rdata[23:8];
                    3'd4:    r_c[4] <= i_i2c_rdata[23:8];
                    3'd5:    r_c[5] <= i_i2c_rdata[23:8];
                    default: r_c[6] <= i_i2c_rdata[23:8];
                endcase
                r_idx <= r_idx + 3'd1;
                if (r_idx == 3'd6) r_cal_vld <= 1'b1;
            end
            if (w_d1_ld) r_d1 <= i_i2c_rdata;
            if (w_d2_ld) r_d2 <= i_i2c_rdata;
            r_sample_vld <= (w_state_nxt == S_DONE);
            r_busy       <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_ERR));
            if (w_state_nxt == S_ERR) r_err <= 1'b1;
        end
    end

    assign o_i2c_addr   = r_addr;
    assign o_i2c_wr_en  = r_wr_en;
    assign o_i2c_rd_en  = r_rd_en;
    assign o_c1         = r_c[1];
    assign o_c2         = r_c[2];
    assign o_c3         = r_c[3];
    assign o_c4         = r_c[4];
    assign o_c5         = r_c[5];
    assign o_c6         = r_c[6];
    assign o_cal_vld    = r_cal_vld;
    assign o_d1         = r_d1;
    assign o_d2         = r_d2;
    assign o_sample_vld = r_sample_vld;
    assign o_busy       = r_busy;
    assign o_err        = r_err;
endmodule
